// File: rtl/fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction-fetch stage behind the PC register. Issues
//                in-order fetches tagged with their PC, buffers returned
//                instructions in a DEPTH-entry queue toward decode, and
//                discards queued/in-flight work on a redirect (flush).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [ADDR_WIDTH-1:0]      pc_i,
    output logic                       pc_en_o,
    input  logic                       flush_i,
    output logic                       imem_req_o,
    output logic [ADDR_WIDTH-1:0]      imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      imem_rdata_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [DATA_WIDTH-1:0]      instr_o,
    output logic [ADDR_WIDTH-1:0]      instr_pc_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_PTR_W = c_IDX_W + 1;
    // DEPTH widened by one bit so it can be compared against count+drop
    localparam logic [c_PTR_W:0] c_DEPTH_X = (c_PTR_W + 1)'(DEPTH);

    // Pointers carry an extra wrap bit so full and empty differ
    logic [c_PTR_W-1:0]    r_alloc_ptr;
    logic [c_PTR_W-1:0]    r_fill_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    r_drop_cnt;

    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [DEPTH-1:0]      r_filled;

    logic [c_IDX_W-1:0]    w_alloc_idx;
    logic [c_IDX_W-1:0]    w_fill_idx;
    logic [c_IDX_W-1:0]    w_head_idx;
    logic [c_PTR_W-1:0]    w_pending;
    logic [c_PTR_W:0]      w_inflight;
    logic                  w_req;
    logic                  w_accept;
    logic                  w_resp_drop;
    logic                  w_resp_fill;
    logic                  w_valid;
    logic                  w_pop;

    // Request/accept/response/pop decode; request withheld during reset and flush
    always_comb begin
        w_alloc_idx = r_alloc_ptr[c_IDX_W-1:0];
        w_fill_idx  = r_fill_ptr[c_IDX_W-1:0];
        w_head_idx  = r_rd_ptr[c_IDX_W-1:0];
        w_pending   = r_alloc_ptr - r_fill_ptr;
        w_inflight  = {1'b0, r_count} + {1'b0, r_drop_cnt};
        w_req       = !rst_i && !flush_i && (w_inflight < c_DEPTH_X);
        w_accept    = w_req && imem_gnt_i;
        // Stale responses owed from before a flush are consumed first
        w_resp_drop = imem_rvalid_i && (r_drop_cnt != '0);
        w_resp_fill = imem_rvalid_i && (r_drop_cnt == '0) && (w_pending != '0);
        w_valid     = (r_count != '0) && r_filled[w_head_idx];
        w_pop       = w_valid && instr_ready_i;
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = pc_i;
    assign pc_en_o       = !rst_i && (w_accept || flush_i);
    assign count_o       = r_count;
    assign instr_valid_o = w_valid;
    // Head fields are masked when not valid so no stale word is ever presented
    assign instr_o       = w_valid ? r_data_mem[w_head_idx] : '0;
    assign instr_pc_o    = w_valid ? r_pc_mem[w_head_idx]   : '0;

    // Pointer, occupancy and drop bookkeeping; flush clears the queue and
    // converts every still-pending fetch into a response to be discarded
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_drop_cnt  <= '0;
        end else if (flush_i) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_drop_cnt  <= r_drop_cnt + w_pending
                           - c_PTR_W'(w_resp_drop || w_resp_fill);
        end else begin
            if (w_accept)    r_alloc_ptr <= r_alloc_ptr + 1'b1;
            if (w_resp_fill) r_fill_ptr  <= r_fill_ptr + 1'b1;
            if (w_pop)       r_rd_ptr    <= r_rd_ptr + 1'b1;
            if (w_resp_drop) r_drop_cnt  <= r_drop_cnt - 1'b1;
            r_count <= r_count + c_PTR_W'(w_accept) - c_PTR_W'(w_pop);
        end
    end

    // Per-slot filled flag: cleared on allocation, set when its response lands
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_filled <= '0;
        end else if (flush_i) begin
            r_filled <= '0;
        end else begin
            if (w_accept)    r_filled[w_alloc_idx] <= 1'b0;
            if (w_resp_fill) r_filled[w_fill_idx]  <= 1'b1;
        end
    end

    // Slot payload storage; contents are only observed through filled/valid
    always_ff @(posedge clk_i) begin
        if (w_accept)    r_pc_mem[w_alloc_idx]  <= pc_i;
        if (w_resp_fill) r_data_mem[w_fill_idx] <= imem_rdata_i;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue with an in-order
//                memory, an external PC register and a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] pc_i = '0;
    logic          pc_en_o;
    logic          flush_i = 1'b0;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i = 1'b0;
    logic          imem_rvalid_i = 1'b0;
    logic [DW-1:0] imem_rdata_i = '0;
    logic          instr_valid_o;
    logic          instr_ready_i = 1'b0;
    logic [DW-1:0] instr_o;
    logic [AW-1:0] instr_pc_o;
    logic [CW-1:0] count_o;

    fetch_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pc_i          (pc_i),
        .pc_en_o       (pc_en_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Environment: in-order instruction memory
    typedef struct { logic [AW-1:0] addr; int due; } mreq_t;
    mreq_t mem_q[$];
    int          lat_max = 1;
    bit          rv_en = 1'b1;
    logic [AW-1:0] flush_target = '0;

    // Reference model: ordered list of allocated entries plus owed drops
    typedef struct { logic [AW-1:0] pc; logic [DW-1:0] data; bit filled; } ent_t;
    ent_t mq[$];
    int   mdrop = 0;

    bit            e_req, e_acc, e_pc_en, e_valid;
    int            e_count;
    logic [DW-1:0] e_instr;
    logic [AW-1:0] e_ipc;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic drive_mem();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = DW'($urandom());
        if (rv_en && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(mem_q[0].addr);
        end
    endtask

    task automatic settle();
        #1;
        e_count = mq.size();
        e_req   = !rst_i && !flush_i && (mq.size() + mdrop < DEPTH);
        e_acc   = e_req && imem_gnt_i;
        e_pc_en = e_acc || (flush_i && !rst_i);
        e_valid = (mq.size() > 0) && mq[0].filled;
        e_instr = '0;
        e_ipc   = '0;
        if (e_valid) begin
            e_instr = mq[0].data;
            e_ipc   = mq[0].pc;
        end
    endtask

    task automatic advance();
        bit            l_acc, l_flush, l_rv, l_pop, l_dut_acc, l_dut_pen;
        logic [DW-1:0] l_rdata;
        logic [AW-1:0] l_pc;
        int            pend, resp;
        mreq_t         r;
        ent_t          e;
        l_acc     = e_acc;
        l_flush   = flush_i;
        l_rv      = imem_rvalid_i;
        l_rdata   = imem_rdata_i;
        l_pc      = pc_i;
        l_pop     = e_valid && instr_ready_i;
        l_dut_acc = imem_req_o && imem_gnt_i;
        l_dut_pen = pc_en_o;
        @(posedge clk_i);
        #1;
        if (l_rv) mem_q.delete(0);
        if (l_dut_acc) begin
            r.addr = l_pc;
            r.due  = cyc + int'($urandom_range(1, lat_max));
            mem_q.push_back(r);
        end
        if (l_dut_pen) pc_i = l_flush ? flush_target : l_pc + 32'd4;
        if (l_flush) begin
            pend = 0;
            foreach (mq[i]) if (!mq[i].filled) pend++;
            resp  = (l_rv && (mdrop > 0 || pend > 0)) ? 1 : 0;
            mdrop = mdrop + pend - resp;
            mq.delete();
        end else begin
            if (l_rv) begin
                if (mdrop > 0) begin
                    mdrop--;
                end else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            e = mq[i]; e.filled = 1'b1; e.data = l_rdata; mq[i] = e;
                            break;
                        end
                    end
                end
            end
            if (l_pop) mq.delete(0);
            if (l_acc) begin
                e.pc = l_pc; e.data = '0; e.filled = 1'b0;
                mq.push_back(e);
            end
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; flush_i = 1'b0; imem_gnt_i = 1'b0; instr_ready_i = 1'b0;
        imem_rvalid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        mem_q.delete(); mq.delete(); mdrop = 0; pc_i = '0; lat_max = 1; rv_en = 1'b1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        // Four fetches outstanding with no responses yet
        imem_gnt_i = 1'b1; instr_ready_i = 1'b0; rv_en = 1'b0;
        for (int k = 0; k < 5; k++) begin drive_mem(); settle(); advance(); end
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req_o); end
        total++; if (pc_en_o !== 1'b0) begin bad++; $display("FAIL rst_pc_en got=%0b exp=0", pc_en_o); end
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", instr_valid_o); end
        total++; if (count_o !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count_o); end
        total++; if (instr_o !== '0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr_o); end
        total++; if (instr_pc_o !== '0) begin bad++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc_o); end
        mq.delete(); mdrop = 0; pc_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        // Responses to pre-reset fetches must be ignored
        rv_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_mem(); settle();
            total++;
            if (instr_valid_o !== 1'b0 || count_o !== '0) begin
                bad++; $display("FAIL post_rst_ignore valid=%0b count=%0d exp valid=0 count=0", instr_valid_o, count_o);
            end
            advance();
        end
    endtask

    task automatic test_streaming();
        logic [AW-1:0] exp_pc;
        do_reset();
        imem_gnt_i = 1'b1; instr_ready_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive_mem(); settle();
            total++;
            if (k < 2) begin
                if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL stream_fill k=%0d valid=%0b exp=0", k, instr_valid_o); end
            end else begin
                exp_pc = AW'((k - 2) * 4);
                if (instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
                    bad++;
                    $display("FAIL stream k=%0d valid=%0b pc=%h instr=%h exp valid=1 pc=%h instr=%h",
                             k, instr_valid_o, instr_pc_o, instr_o, exp_pc, mem_word(exp_pc));
                end
            end
            advance();
        end
    endtask

    task automatic test_full_stall();
        int acc;
        do_reset();
        imem_gnt_i = 1'b1; instr_ready_i = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            drive_mem(); settle();
            if (imem_req_o && imem_gnt_i) acc++;
            advance();
        end
        total++; if (acc != 4) begin bad++; $display("FAIL full_grants got=%0d exp=4", acc); end
        instr_ready_i = 1'b1;
        drive_mem(); settle();
        total++;
        if (imem_req_o !== 1'b0 || pc_en_o !== 1'b0 || count_o !== CW'(4) || imem_addr_o !== 32'h10) begin
            bad++;
            $display("FAIL full_hold req=%0b pc_en=%0b count=%0d addr=%h exp 0 0 4 00000010",
                     imem_req_o, pc_en_o, count_o, imem_addr_o);
        end
        advance();
        instr_ready_i = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            drive_mem(); settle();
            if (imem_req_o && imem_gnt_i) acc++;
            advance();
        end
        drive_mem(); settle();
        total++;
        if (acc != 1 || imem_addr_o !== 32'h14) begin
            bad++; $display("FAIL full_one_more grants=%0d addr=%h exp grants=1 addr=00000014", acc, imem_addr_o);
        end
    endtask

    task automatic test_mem_stall();
        do_reset();
        instr_ready_i = 1'b1; imem_gnt_i = 1'b1;
        for (int k = 0; k < 2; k++) begin drive_mem(); settle(); advance(); end
        imem_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_mem(); settle();
            total++;
            if (pc_en_o !== 1'b0 || imem_addr_o !== 32'h8) begin
                bad++; $display("FAIL stall k=%0d pc_en=%0b addr=%h exp pc_en=0 addr=00000008", k, pc_en_o, imem_addr_o);
            end
            advance();
        end
        imem_gnt_i = 1'b1;
        drive_mem(); settle();
        total++; if (pc_en_o !== 1'b1) begin bad++; $display("FAIL stall_release pc_en=%0b exp=1", pc_en_o); end
        advance();
        imem_gnt_i = 1'b0;
        drive_mem(); settle();
        total++; if (imem_addr_o !== 32'hC) begin bad++; $display("FAIL stall_advance addr=%h exp=0000000c", imem_addr_o); end
        advance();
    endtask

    task automatic test_flush();
        bit seen;
        do_reset();
        instr_ready_i = 1'b1; rv_en = 1'b0; imem_gnt_i = 1'b1;
        for (int k = 0; k < 2; k++) begin drive_mem(); settle(); advance(); end
        imem_gnt_i = 1'b0;
        flush_i = 1'b1; flush_target = 32'h100;
        drive_mem(); settle();
        total++;
        if (pc_en_o !== 1'b1 || imem_req_o !== 1'b0) begin
            bad++; $display("FAIL flush_cycle pc_en=%0b req=%0b exp pc_en=1 req=0", pc_en_o, imem_req_o);
        end
        advance();
        flush_i = 1'b0;
        drive_mem(); settle();
        total++;
        if (instr_valid_o !== 1'b0 || count_o !== '0) begin
            bad++; $display("FAIL flush_after valid=%0b count=%0d exp 0 0", instr_valid_o, count_o);
        end
        rv_en = 1'b1; imem_gnt_i = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            drive_mem(); settle();
            if (instr_valid_o) begin
                seen = 1'b1;
                total++;
                if (instr_pc_o !== 32'h100 || instr_o !== mem_word(32'h100)) begin
                    bad++; $display("FAIL flush_target pc=%h instr=%h exp pc=00000100 instr=%h",
                                    instr_pc_o, instr_o, mem_word(32'h100));
                end
            end
            advance();
        end
        if (!seen) begin total++; bad++; $display("FAIL flush_timeout no valid instruction within 20 cycles"); end
        imem_gnt_i = 1'b0;
    endtask

    task automatic test_flush_coincident();
        bit seen;
        do_reset();
        instr_ready_i = 1'b0; rv_en = 1'b0; imem_gnt_i = 1'b1;
        for (int k = 0; k < 3; k++) begin drive_mem(); settle(); advance(); end
        imem_gnt_i = 1'b0; rv_en = 1'b1;
        drive_mem(); settle(); advance();
        // Flush together with a fill (second fetch) and a pop (first fetch)
        instr_ready_i = 1'b1; flush_i = 1'b1; flush_target = 32'h200;
        drive_mem(); settle();
        total++;
        if (imem_rvalid_i !== 1'b1 || instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== mem_word(32'h0)) begin
            bad++; $display("FAIL coinc_pop rvalid=%0b valid=%0b pc=%h instr=%h exp 1 1 00000000 %h",
                            imem_rvalid_i, instr_valid_o, instr_pc_o, instr_o, mem_word(32'h0));
        end
        advance();
        flush_i = 1'b0;
        drive_mem(); settle();
        total++;
        if (instr_valid_o !== 1'b0 || count_o !== '0) begin
            bad++; $display("FAIL coinc_empty valid=%0b count=%0d exp 0 0", instr_valid_o, count_o);
        end
        imem_gnt_i = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            drive_mem(); settle();
            if (instr_valid_o) begin
                seen = 1'b1;
                total++;
                if (instr_pc_o !== 32'h200 || instr_o !== mem_word(32'h200)) begin
                    bad++; $display("FAIL coinc_target pc=%h instr=%h exp pc=00000200 instr=%h",
                                    instr_pc_o, instr_o, mem_word(32'h200));
                end
            end
            advance();
        end
        if (!seen) begin total++; bad++; $display("FAIL coinc_timeout no valid instruction within 20 cycles"); end
        imem_gnt_i = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        lat_max = 3;
        for (int k = 0; k < 600; k++) begin
            imem_gnt_i    = ($urandom() % 4) != 0;
            instr_ready_i = ($urandom() % 3) != 0;
            rv_en         = ($urandom() % 4) != 0;
            flush_i       = ($urandom() % 20) == 0;
            if (flush_i) flush_target = $urandom() & 32'hFFFF_FFFC;
            drive_mem(); settle();
            total++;
            if (imem_req_o !== e_req || pc_en_o !== e_pc_en || imem_addr_o !== pc_i) begin
                bad++; $display("FAIL rnd_req k=%0d req=%0b pc_en=%0b addr=%h exp %0b %0b %h",
                                k, imem_req_o, pc_en_o, imem_addr_o, e_req, e_pc_en, pc_i);
            end
            total++;
            if (instr_valid_o !== e_valid || count_o !== CW'(e_count)) begin
                bad++; $display("FAIL rnd_queue k=%0d valid=%0b count=%0d exp %0b %0d",
                                k, instr_valid_o, count_o, e_valid, e_count);
            end
            if (e_valid) begin
                total++;
                if (instr_o !== e_instr || instr_pc_o !== e_ipc) begin
                    bad++; $display("FAIL rnd_head k=%0d instr=%h pc=%h exp %h %h",
                                    k, instr_o, instr_pc_o, e_instr, e_ipc);
                end
            end
            advance();
        end
        flush_i = 1'b0; imem_gnt_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_full_stall();
        test_mem_stall();
        test_flush();
        test_flush_coincident();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
